fpm16_norm_ctrl: RTL and testbench

- Sequences normalization of the 22-bit FP16 mantissa product: forwards the product to the shared leading-one detector, waits out its fixed latency, converts the detector's one-hot result to a shift count, shifts the product and adjusts the exponent.
- Sits between the mantissa multiplier stage and the rounding stage.
- Uses valid/ready handshakes on both sides and handles one transaction at a time.

---
 rtl/fpm16_pkg.sv | 19 +
 rtl/fpm16_onehot_enc.sv | 23 ++
 rtl/fpm16_norm_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fpm16_norm_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpm16_pkg.sv
// Shared constants and state type for the FP16 multiplier
// normalization control.
package fpm16_pkg;

    localparam int PROD_W   = 22;
    localparam int MANT_W   = 10;
    localparam int EXP_W    = 5;
    localparam int EXPI_W   = 7;
    localparam int BIAS     = 15;
    localparam int ONEHOT_W = 21;
    localparam int IDX_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOD_WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/fpm16_onehot_enc.sv
// One-hot to index encoder for the leading-one detector result.
// Multi-hot inputs resolve to the highest set bit.
module fpm16_onehot_enc
    import fpm16_pkg::*;
(
    input  logic [ONEHOT_W-1:0] onehot_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                none_o
);

    // Ascending scan so the highest set bit is the last one written
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < ONEHOT_W; i++) begin
            if (onehot_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign none_o = ~|onehot_i;

endmodule

// File: rtl/fpm16_norm_ctrl.sv
// Normalization sequencer between the mantissa multiplier and the
// rounding stage: leading-one lookup, shift, exponent adjust, limits.
module fpm16_norm_ctrl
    import fpm16_pkg::*;
#(
    parameter int LOD_LAT = 2,
    parameter int EXP_MAX = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PROD_W-1:0]   in_prod,
    input  logic [EXPI_W-1:0]   in_exp,
    output logic [PROD_W-1:0]   lod_in,
    input  logic [ONEHOT_W-1:0] lod_onehot,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MANT_W-1:0]   out_mant,
    output logic [EXP_W-1:0]    out_exp,
    output logic                out_sticky,
    output logic                out_zero,
    output logic                out_ovf,
    output logic                out_unf
);

    localparam int CNT_W = $clog2(LOD_LAT + 2);
    localparam logic signed [7:0] EXP_MAX_S = 8'(EXP_MAX);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PROD_W-1:0]   prod_q;
    logic [EXPI_W-1:0]   exp_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [PROD_W-1:0]   lod_in_q;
    logic [MANT_W-1:0]   mant_q;
    logic [EXP_W-1:0]    exp_out_q;
    logic                sticky_q;
    logic                zero_q;
    logic                ovf_q;
    logic                unf_q;

    logic [IDX_W-1:0]    lead_idx;
    logic                lead_none;
    logic [IDX_W-1:0]    shamt;
    logic [19:0]         shl;
    logic signed [7:0]   exp_wide;
    logic signed [7:0]   exp_s;
    logic [MANT_W-1:0]   mant_d;
    logic [EXP_W-1:0]    exp_d;
    logic                sticky_d;
    logic                zero_d;
    logic                ovf_d;
    logic                unf_d;

    fpm16_onehot_enc u_enc (
        .onehot_i (lod_onehot),
        .idx_o    (lead_idx),
        .none_o   (lead_none)
    );

    // Result datapath: fast right-shift-by-one or LOD-driven left shift
    always_comb begin
        shamt    = IDX_W'(20) - lead_idx;
        shl      = prod_q[19:0] << shamt;
        exp_wide = signed'({exp_q[EXPI_W-1], exp_q});
        exp_s    = '0;
        mant_d   = '0;
        exp_d    = '0;
        sticky_d = 1'b0;
        zero_d   = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (prod_q[PROD_W-1]) begin
            exp_s    = exp_wide + 8'sd1;
            mant_d   = prod_q[20:11];
            sticky_d = |prod_q[10:0];
        end else if (lead_none) begin
            zero_d = 1'b1;
        end else begin
            exp_s    = exp_wide - signed'({3'b000, shamt});
            mant_d   = shl[19:10];
            sticky_d = |shl[9:0];
        end
        if (!zero_d) begin
            if (exp_s >= EXP_MAX_S) begin
                ovf_d    = 1'b1;
                exp_d    = EXP_W'(EXP_MAX);
                mant_d   = '0;
                sticky_d = 1'b0;
            end else if (exp_s <= 8'sd0) begin
                unf_d    = 1'b1;
                mant_d   = '0;
                sticky_d = 1'b1;
            end else begin
                exp_d = exp_s[EXP_W-1:0];
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    // The fast path also passes through LOD_WAIT with a zero count
    // so its result is registered one edge after accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prod_q      <= '0;
            exp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            lod_in_q    <= '0;
            mant_q      <= '0;
            exp_out_q   <= '0;
            sticky_q    <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        prod_q     <= in_prod;
                        exp_q      <= in_exp;
                        lod_in_q   <= in_prod;
                        in_ready_q <= 1'b0;
                        cnt_q      <= in_prod[PROD_W-1] ? '0
                                                        : CNT_W'(LOD_LAT);
                        state_q    <= LOD_WAIT;
                    end
                end
                LOD_WAIT: begin
                    if (cnt_q == '0) begin
                        mant_q      <= mant_d;
                        exp_out_q   <= exp_d;
                        sticky_q    <= sticky_d;
                        zero_q      <= zero_d;
                        ovf_q       <= ovf_d;
                        unf_q       <= unf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign lod_in     = lod_in_q;
    assign out_mant   = mant_q;
    assign out_exp    = exp_out_q;
    assign out_sticky = sticky_q;
    assign out_zero   = zero_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;

endmodule

// File: tb/tb_fpm16_norm_ctrl.sv
// Directed bench for fpm16_norm_ctrl with a two-stage detector model
// that forwards lod_in[20:0] (multi-hot) after two clocks.
module tb_fpm16_norm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [21:0] in_prod = '0;
    logic [6:0]  in_exp = '0;
    logic        in_ready;
    logic [21:0] lod_in;
    logic [20:0] lod_onehot;
    logic        out_valid;
    logic [9:0]  out_mant;
    logic [4:0]  out_exp;
    logic        out_sticky;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;
    logic [20:0] lod_d1 = '0;
    logic [20:0] lod_d2 = '0;
    logic [18:0] res;
    int          tests = 0;
    int          fails = 0;

    fpm16_norm_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_exp     (in_exp),
        .lod_in     (lod_in),
        .lod_onehot (lod_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_sticky (out_sticky),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    always #5 clk = ~clk;

    // Detector model: two register stages from lod_in
    always @(posedge clk) begin
        lod_d1 <= lod_in[20:0];
        lod_d2 <= lod_d1;
    end
    assign lod_onehot = lod_d2;

    // {zero, ovf, unf, sticky, exp, mant}
    assign res = {out_zero, out_ovf, out_unf, out_sticky, out_exp, out_mant};

    task automatic issue(input logic [21:0] p, input logic [6:0] e);
        in_valid = 1'b1;
        in_prod  = p;
        in_exp   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests++;
        if (lod_in !== 22'h0) begin
            fails++;
            $display("FAIL reset_lod_in: got %h expected 000000", lod_in);
        end
        tests++;
        if (res !== 19'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 00000", res);
        end
    endtask

    task automatic test_fast();
        logic [21:0] p [2] = '{22'h200000, 22'h3FF801};
        logic [6:0]  e [2] = '{7'd15, 7'd15};
        logic [18:0] x [2] = '{{4'b0000, 5'd16, 10'h000},
                               {4'b0001, 5'd16, 10'h3FF}};
        int lat;
        for (int i = 0; i < 2; i++) begin
            issue(p[i], e[i]);
            tests++;
            if (lod_in !== p[i]) begin
                fails++;
                $display("FAIL fast_lod_in[%0d]: got %h expected %h",
                         i, lod_in, p[i]);
            end
            wait_valid(lat);
            tests++;
            if (lat != 1) begin
                fails++;
                $display("FAIL fast_lat[%0d]: got %0d expected 1", i, lat);
            end
            tests++;
            if (res !== x[i]) begin
                fails++;
                $display("FAIL fast_res[%0d]: got %h expected %h",
                         i, res, x[i]);
            end
            drain();
            tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL fast_hs[%0d]: got rdy=%b vld=%b expected 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_lod();
        logic [21:0] p [3] = '{22'h0C0000, 22'h0A0003, 22'h100000};
        logic [6:0]  e [3] = '{7'd15, 7'd15, 7'd30};
        logic [18:0] x [3] = '{{4'b0000, 5'd14, 10'h200},
                               {4'b0001, 5'd14, 10'h100},
                               {4'b0000, 5'd30, 10'h000}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(p[i], e[i]);
            wait_valid(lat);
            tests++;
            if (lat != 3) begin
                fails++;
                $display("FAIL lod_lat[%0d]: got %0d expected 3", i, lat);
            end
            tests++;
            if (res !== x[i]) begin
                fails++;
                $display("FAIL lod_res[%0d]: got %h expected %h",
                         i, res, x[i]);
            end
            drain();
        end
    endtask

    task automatic test_limits();
        logic [21:0] p [6] = '{22'h000001, 22'h000000, 22'h300000,
                               22'h100000, 22'h100000, 22'h100000};
        logic [6:0]  e [6] = '{7'd10, 7'd15, 7'd30, 7'd0, 7'd1, 7'd31};
        int          l [6] = '{3, 3, 1, 3, 3, 3};
        logic [18:0] x [6] = '{{4'b0011, 5'd0, 10'h000},
                               {4'b1000, 5'd0, 10'h000},
                               {4'b0100, 5'd31, 10'h000},
                               {4'b0011, 5'd0, 10'h000},
                               {4'b0000, 5'd1, 10'h000},
                               {4'b0100, 5'd31, 10'h000}};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(p[i], e[i]);
            wait_valid(lat);
            tests++;
            if (lat != l[i]) begin
                fails++;
                $display("FAIL lim_lat[%0d]: got %0d expected %0d",
                         i, lat, l[i]);
            end
            tests++;
            if (res !== x[i]) begin
                fails++;
                $display("FAIL lim_res[%0d]: got %h expected %h",
                         i, res, x[i]);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] x = {4'b0000, 5'd16, 10'h000};
        int lat;
        issue(22'h200000, 7'd15);
        wait_valid(lat);
        tests++;
        if (lat != 1) begin
            fails++;
            $display("FAIL bp_lat: got %0d expected 1", lat);
        end
        in_valid = 1'b1;
        in_prod  = 22'h0C0000;
        in_exp   = 7'd3;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || res !== x ||
                lod_in !== 22'h200000) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%h lod=%h expected 1 0 %h 200000",
                         c, out_valid, in_ready, res, lod_in, x);
            end
        end
        in_valid = 1'b0;
        drain();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            lod_in !== 22'h200000) begin
            fails++;
            $display("FAIL bp_release: got vld=%b rdy=%b lod=%h expected 0 1 200000",
                     out_valid, in_ready, lod_in);
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] x = {4'b0000, 5'd6, 10'h200};
        int lat;
        issue(22'h0C0000, 7'd15);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            lod_in !== 22'h0 || res !== 19'h0) begin
            fails++;
            $display("FAIL rmid_clear: got vld=%b rdy=%b lod=%h res=%h expected 0 1 000000 00000",
                     out_valid, in_ready, lod_in, res);
        end
        issue(22'h000003, 7'd25);
        wait_valid(lat);
        tests++;
        if (lat != 3) begin
            fails++;
            $display("FAIL rmid_lat: got %0d expected 3", lat);
        end
        tests++;
        if (res !== x) begin
            fails++;
            $display("FAIL rmid_res: got %h expected %h", res, x);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fast();
        test_lod();
        test_limits();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
